// File: rtl/axi_wr_isolator.sv
// Write-path isolation stage around the write guard: counts outstanding AWs, cuts the
// slave on a guard reset request and answers pending writes with SLVERR.
// Optional: define WR_ISOLATOR_STATS_EN to build the SLVERR response counter (err_cnt_o).

package axi_wr_isolator_pkg;
    typedef logic [3:0] id_t;
    typedef struct packed { id_t id; logic [31:0] addr; logic [7:0] len; } aw_chan_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_chan_t;
    typedef struct packed { id_t id; logic [1:0] resp; logic user; } b_chan_t;
    typedef struct packed { id_t id; logic [31:0] addr; logic [7:0] len; } ar_chan_t;
    typedef struct packed { id_t id; logic [31:0] data; logic [1:0] resp; logic last; } r_chan_t;
    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;
    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } rsp_t;
endpackage

module axi_wr_isolator_fifo #(
    parameter int unsigned Depth  = 8,
    parameter type         data_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push_i,
    input  data_t data_i,
    input  logic  pop_i,
    output data_t data_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    data_t           mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
            if (pop_i)  rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
            cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

    // An empty-FIFO pop is only legal when the same-cycle push supplies the entry.
    a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !pop_i));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o && !push_i));
endmodule

module axi_wr_isolator #(
    parameter int unsigned MaxWrTxns = 8,
    parameter type         req_t     = axi_wr_isolator_pkg::req_t,
    parameter type         rsp_t     = axi_wr_isolator_pkg::rsp_t,
    parameter type         id_t      = axi_wr_isolator_pkg::id_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  req_t        mst_req_i,
    output rsp_t        mst_rsp_o,
    output req_t        slv_req_o,
    input  rsp_t        slv_rsp_i,
    output logic        wr_en_o,
    input  logic        guard_reset_i,
    input  logic        slv_rst_done_i,
    output logic        reset_clear_o,
    output logic        isolated_o,
    output logic [15:0] err_cnt_o
);
    typedef enum logic [1:0] {PASS, ISO, CLEAR} state_e;

    state_e state_q;
    logic   isolated_q, clear_q, skip_q;
    logic   idf_push, idf_pop, idf_full, idf_empty;
    logic   bf_push, bf_pop, bf_full, bf_empty;
    id_t    idf_head, bf_head;
    logic   iso_exit, aw_rdy, w_rdy, b_vld;

    assign iso_exit = (state_q == ISO) && slv_rst_done_i && idf_empty && bf_empty;

    axi_wr_isolator_fifo #(.Depth(MaxWrTxns), .data_t(id_t)) u_idf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (idf_push),
        .data_i (mst_req_i.aw.id),
        .pop_i  (idf_pop),
        .data_o (idf_head),
        .full_o (idf_full),
        .empty_o(idf_empty)
    );

    axi_wr_isolator_fifo #(.Depth(MaxWrTxns), .data_t(id_t)) u_bf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (bf_push),
        .data_i (idf_head),
        .pop_i  (bf_pop),
        .data_o (bf_head),
        .full_o (bf_full),
        .empty_o(bf_empty)
    );

    always_comb begin
        slv_req_o = mst_req_i;
        mst_rsp_o = slv_rsp_i;
        wr_en_o   = 1'b0;
        idf_push  = 1'b0;
        idf_pop   = 1'b0;
        bf_push   = 1'b0;
        bf_pop    = 1'b0;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        b_vld     = 1'b0;
        case (state_q)
            PASS: begin
                slv_req_o.aw_valid = mst_req_i.aw_valid & ~idf_full;
                mst_rsp_o.aw_ready = slv_rsp_i.aw_ready & ~idf_full;
                wr_en_o  = slv_req_o.aw_valid & slv_rsp_i.aw_ready;
                idf_push = wr_en_o;
                // A last beat racing its own AW into an empty FIFO cancels out.
                idf_pop  = mst_req_i.w_valid & slv_rsp_i.w_ready & mst_req_i.w.last
                         & (~idf_empty | idf_push);
            end
            ISO: begin
                slv_req_o.aw_valid = 1'b0;
                slv_req_o.w_valid  = 1'b0;
                slv_req_o.b_ready  = 1'b1;
                // Hold new AWs once exit is decided so none is stranded across CLEAR.
                aw_rdy = ~idf_full & ~iso_exit;
                w_rdy  = ~idf_empty & (~mst_req_i.w.last | ~bf_full);
                b_vld  = ~bf_empty;
                mst_rsp_o.aw_ready = aw_rdy;
                mst_rsp_o.w_ready  = w_rdy;
                mst_rsp_o.b_valid  = b_vld;
                mst_rsp_o.b.id     = bf_head;
                mst_rsp_o.b.resp   = 2'b10;
                mst_rsp_o.b.user   = '0;
                idf_push = mst_req_i.aw_valid & aw_rdy;
                idf_pop  = mst_req_i.w_valid & w_rdy & mst_req_i.w.last;
                bf_push  = idf_pop;
                bf_pop   = b_vld & mst_req_i.b_ready;
            end
            default: begin
                slv_req_o.aw_valid = 1'b0;
                slv_req_o.w_valid  = 1'b0;
                slv_req_o.b_ready  = 1'b1;
                mst_rsp_o.aw_ready = 1'b0;
                mst_rsp_o.w_ready  = 1'b0;
                mst_rsp_o.b_valid  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= PASS;
            isolated_q <= 1'b0;
            clear_q    <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            skip_q  <= 1'b0;
            case (state_q)
                PASS: if (guard_reset_i && !skip_q) begin
                    state_q    <= ISO;
                    isolated_q <= 1'b1;
                end
                ISO: if (iso_exit) begin
                    state_q <= CLEAR;
                    clear_q <= 1'b1;
                end
                CLEAR: begin
                    // The guard's registered request needs one more cycle to drop.
                    state_q    <= PASS;
                    isolated_q <= 1'b0;
                    skip_q     <= 1'b1;
                end
                default: begin
                    state_q    <= PASS;
                    isolated_q <= 1'b0;
                end
            endcase
        end
    end

    assign isolated_o    = isolated_q;
    assign reset_clear_o = clear_q;

`ifdef WR_ISOLATOR_STATS_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_cnt_q <= '0;
        else if (bf_pop && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_axi_wr_isolator.sv
// Directed bench for axi_wr_isolator (MaxWrTxns=2); expected B responses go through a
// scoreboard queue that a negedge monitor drains on every master B handshake.

module tb_axi_wr_isolator;
    import axi_wr_isolator_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    req_t        mst_req, slv_req;
    rsp_t        mst_rsp, slv_rsp;
    logic        wr_en, guard_reset, slv_rst_done, reset_clear, isolated;
    logic [15:0] err_cnt;

    typedef struct { logic [3:0] id; logic [1:0] resp; } exp_b_t;
    exp_b_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_wr_isolator #(.MaxWrTxns(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mst_req_i     (mst_req),
        .mst_rsp_o     (mst_rsp),
        .slv_req_o     (slv_req),
        .slv_rsp_i     (slv_rsp),
        .wr_en_o       (wr_en),
        .guard_reset_i (guard_reset),
        .slv_rst_done_i(slv_rst_done),
        .reset_clear_o (reset_clear),
        .isolated_o    (isolated),
        .err_cnt_o     (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_b(input logic [3:0] id, input logic [1:0] resp);
        exp_b_t e;
        e.id   = id;
        e.resp = resp;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && mst_rsp.b_valid && mst_req.b_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_b", {28'd0, mst_rsp.b.id}, 32'hFFFF_FFFF);
            end else begin
                exp_b_t e;
                e = exp_q.pop_front();
                chk("b_id", {28'd0, mst_rsp.b.id}, {28'd0, e.id});
                chk("b_resp", {30'd0, mst_rsp.b.resp}, {30'd0, e.resp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        mst_req      = '0;
        slv_rsp      = '0;
        slv_rsp.aw_ready = 1'b1;
        slv_rsp.w_ready  = 1'b1;
        guard_reset  = 1'b0;
        slv_rst_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_isolated", {31'd0, isolated}, 0);
        chk("rst_clear", {31'd0, reset_clear}, 0);
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 0);
        rst_n = 1'b1;
        mst_req.b_ready = 1'b1;

        // PASS: one 4-beat write, slave answers OKAY
        step(); mst_req.aw_valid = 1'b1; mst_req.aw.id = 4'd3; mst_req.aw.len = 8'd3;
        @(negedge clk); chk("t1_wr_en_hs", {31'd0, wr_en}, 1);
        step(); mst_req.aw_valid = 1'b0; mst_req.w_valid = 1'b1; mst_req.w.last = 1'b0;
        @(negedge clk); chk("t1_wr_en_after", {31'd0, wr_en}, 0);
        step();
        step(); 
        step(); mst_req.w.last = 1'b1;
        step(); mst_req.w_valid = 1'b0; mst_req.w.last = 1'b0;
        @(negedge clk); chk("t1_idf_empty", {31'd0, dut.idf_empty}, 1);
        step(); exp_b(4'd3, 2'b00);
        slv_rsp.b_valid = 1'b1; slv_rsp.b.id = 4'd3; slv_rsp.b.resp = 2'b00;
        step(); slv_rsp.b_valid = 1'b0;

        // Guard reset in the middle of a W burst: remainder drained, SLVERR returned
        step(); mst_req.aw_valid = 1'b1; mst_req.aw.id = 4'd5; mst_req.aw.len = 8'd3;
        step(); mst_req.aw_valid = 1'b0; mst_req.w_valid = 1'b1;
        step();
        step(); mst_req.w_valid = 1'b0; guard_reset = 1'b1;
        @(negedge clk); chk("t2_not_yet_iso", {31'd0, isolated}, 0);
        step(); mst_req.w_valid = 1'b1;
        @(negedge clk);
        chk("t2_isolated", {31'd0, isolated}, 1);
        chk("t2_slv_w_valid", {31'd0, slv_req.w_valid}, 0);
        chk("t2_slv_b_ready", {31'd0, slv_req.b_ready}, 1);
        chk("t2_mst_w_ready", {31'd0, mst_rsp.w_ready}, 1);
        exp_b(4'd5, 2'b10);
        step(); mst_req.w.last = 1'b1;
        step(); mst_req.w_valid = 1'b0; mst_req.w.last = 1'b0;
        step();

        // ISO: ids 1,2,1, depth 2 blocks the third AW until the first last beat
        exp_b(4'd1, 2'b10); exp_b(4'd2, 2'b10); exp_b(4'd1, 2'b10);
        step(); mst_req.aw_valid = 1'b1; mst_req.aw.id = 4'd1;
        @(negedge clk); chk("t3_aw1_ready", {31'd0, mst_rsp.aw_ready}, 1);
        chk("t3_wr_en_iso", {31'd0, wr_en}, 0);
        step(); mst_req.aw.id = 4'd2;
        @(negedge clk); chk("t3_aw2_ready", {31'd0, mst_rsp.aw_ready}, 1);
        step(); mst_req.aw.id = 4'd1;
        @(negedge clk); chk("t4_aw3_blocked", {31'd0, mst_rsp.aw_ready}, 0);
        step();
        @(negedge clk); chk("t4_aw3_still_blocked", {31'd0, mst_rsp.aw_ready}, 0);
        step(); mst_req.w_valid = 1'b1; mst_req.w.last = 1'b1;
        @(negedge clk); chk("t4_aw3_blocked_at_w", {31'd0, mst_rsp.aw_ready}, 0);
        step();
        @(negedge clk); chk("t4_aw3_released", {31'd0, mst_rsp.aw_ready}, 1);
        chk("t3_wr_en_iso2", {31'd0, wr_en}, 0);
        step(); mst_req.aw_valid = 1'b0;
        step(); mst_req.w_valid = 1'b0; mst_req.w.last = 1'b0;
        repeat (4) step();
`ifdef WR_ISOLATOR_STATS_EN
        chk("t3_err_cnt", {16'd0, err_cnt}, 4);
`else
        chk("t3_err_cnt", {16'd0, err_cnt}, 0);
`endif

        // Exit blocked by a pending B until the master accepts it
        mst_req.b_ready = 1'b0;
        step(); mst_req.aw_valid = 1'b1; mst_req.aw.id = 4'd6;
        step(); mst_req.aw_valid = 1'b0; mst_req.w_valid = 1'b1; mst_req.w.last = 1'b1;
        step(); mst_req.w_valid = 1'b0; mst_req.w.last = 1'b0; slv_rst_done = 1'b1;
        exp_b(4'd6, 2'b10);
        repeat (3) step();
        @(negedge clk);
        chk("t5_held_iso", {31'd0, isolated}, 1);
        chk("t5_no_clear", {31'd0, reset_clear}, 0);
        chk("t5_b_pending", {31'd0, mst_rsp.b_valid}, 1);
        step(); mst_req.b_ready = 1'b1;
        step();
        @(negedge clk); chk("t5_clear_not_yet", {31'd0, reset_clear}, 0);
        step();
        @(negedge clk); chk("t5_clear_pulse", {31'd0, reset_clear}, 1);
        chk("t5_iso_in_clear", {31'd0, isolated}, 1);
        step();
        @(negedge clk); chk("t5_clear_gone", {31'd0, reset_clear}, 0);
        chk("t5_pass", {31'd0, isolated}, 0);
        step(); guard_reset = 1'b0;
        @(negedge clk); chk("t5_no_reenter", {31'd0, isolated}, 0);
        slv_rst_done = 1'b0;

        // Reset mid-ISO with both FIFOs holding entries
        step(); guard_reset = 1'b1;
        step(); mst_req.b_ready = 1'b0; mst_req.aw_valid = 1'b1; mst_req.aw.id = 4'd7;
        step(); mst_req.aw.id = 4'd8; mst_req.w_valid = 1'b1; mst_req.w.last = 1'b1;
        step(); mst_req.aw_valid = 1'b0; mst_req.w_valid = 1'b0; mst_req.w.last = 1'b0;
        @(negedge clk);
        chk("t6_idf_busy", {31'd0, dut.idf_empty}, 0);
        chk("t6_bf_busy", {31'd0, dut.bf_empty}, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_isolated", {31'd0, isolated}, 0);
        chk("t6_rst_b_valid", {31'd0, mst_rsp.b_valid}, 0);
        chk("t6_rst_clear", {31'd0, reset_clear}, 0);
        chk("t6_rst_err_cnt", {16'd0, err_cnt}, 0);
        chk("t6_rst_idf", {31'd0, dut.idf_empty}, 1);
        chk("t6_rst_bf", {31'd0, dut.bf_empty}, 1);
        guard_reset = 1'b0;
        mst_req.b_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        repeat (6) step();
        @(negedge clk); chk("t6_post_rst_pass", {31'd0, isolated}, 0);

        begin
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 50) begin
                step();
                t++;
            end
        end
        chk("b_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
